seq_scan_ctrl: RTL and testbench

SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

---
 rtl/seq_scan_ctrl.sv | 113 +++++++++++
 tb/tb_seq_scan_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/seq_scan_ctrl.sv
// Serial pattern scanner: shifts a captured stream MSB-first through an N-bit window,
// flagging, counting and locating matches against a captured code. Supports abort.
module seq_scan_ctrl #(
  parameter int N  = 4,
  parameter int W  = 16,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_valid,
  output logic          start_ready,
  input  logic [N-1:0]  code,
  input  logic [N-1:0]  seed,
  input  logic [W-1:0]  stream,
  input  logic          abort,
  output logic          busy,
  output logic          hit,
  output logic          done,
  output logic          aborted,
  output logic [CW-1:0] match_cnt,
  output logic          found,
  output logic [CW-1:0] first_pos
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  code_r;
  logic [N-1:0]  window;
  logic [W-1:0]  stream_r;
  logic [CW-1:0] idx;
  logic [N-1:0]  win_nxt;
  logic          match;
  logic          last;
  logic          accept;
  logic          do_shift;

  // Stream register shifts left each step, so the bit to consume is always the MSB
  assign win_nxt  = {window[N-2:0], stream_r[W-1]};
  assign match    = (win_nxt == code_r);
  assign last     = (idx == CW'(W - 1));
  assign accept   = (state == IDLE) && start_valid;
  assign do_shift = (state == SHIFT) && !abort;

  assign start_ready = (state == IDLE);
  assign busy        = (state == SHIFT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_valid) state_nxt = SHIFT;
      SHIFT: begin
        if (abort)     state_nxt = IDLE;
        else if (last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      window    <= '0;
      idx       <= '0;
      hit       <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      match_cnt <= '0;
      found     <= 1'b0;
      first_pos <= '0;
    end else begin
      state   <= state_nxt;
      hit     <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      if (accept) begin
        window    <= seed;
        idx       <= '0;
        match_cnt <= '0;
        found     <= 1'b0;
        first_pos <= '0;
      end else if (state == SHIFT) begin
        if (abort) begin
          aborted <= 1'b1;
        end else begin
          window <= win_nxt;
          idx    <= idx + 1'b1;
          hit    <= match;
          done   <= last;
          if (match) begin
            match_cnt <= match_cnt + 1'b1;
            if (!found) begin
              found     <= 1'b1;
              first_pos <= idx;
            end
          end
        end
      end
    end
  end

  // Job data: captured on accept, no reset needed since it is only read in SHIFT
  always_ff @(posedge clk) begin
    if (accept) begin
      code_r   <= code;
      stream_r <= stream;
    end else if (do_shift) begin
      stream_r <= stream_r << 1;
    end
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl (N=4, W=8): basic, overlap, no-match, abort,
// abort on final edge with start_valid held, and async reset mid-job.
module tb_seq_scan_ctrl;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_valid = 1'b0;
  logic          start_ready;
  logic [N-1:0]  code = '0;
  logic [N-1:0]  seed = '0;
  logic [W-1:0]  stream = '0;
  logic          abort = 1'b0;
  logic          busy, hit, done, aborted, found;
  logic [CW-1:0] match_cnt, first_pos;

  int n_cmp = 0;
  int n_err = 0;

  seq_scan_ctrl #(.N(N), .W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .code(code), .seed(seed), .stream(stream), .abort(abort), .busy(busy),
    .hit(hit), .done(done), .aborted(aborted), .match_cnt(match_cnt),
    .found(found), .first_pos(first_pos)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_results(input string nm, input int ecnt, input int efound, input int epos);
    chk({nm, "_cnt"},   32'(match_cnt), 32'(ecnt));
    chk({nm, "_found"}, 32'(found),     32'(efound));
    chk({nm, "_pos"},   32'(first_pos), 32'(epos));
  endtask

  // Full job: accept, W shifts checking hit per index, done on edge W, ready after W+1
  task automatic run_job(input string nm, input logic [3:0] c, input logic [3:0] s,
                         input logic [7:0] st, input logic [7:0] eh,
                         input int ecnt, input int efound, input int epos);
    chk({nm, "_ready0"}, 32'(start_ready), 32'd1);
    code = c; seed = s; stream = st; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < W; i++) begin
      tick();
      chk($sformatf("%s_hit%0d", nm, i), 32'(hit), 32'(eh[i]));
      chk($sformatf("%s_done%0d", nm, i), 32'(done), (i == W - 1) ? 32'd1 : 32'd0);
    end
    chk({nm, "_busy_done"}, 32'(busy), 32'd0);
    tick();
    chk({nm, "_done_off"}, 32'(done), 32'd0);
    chk({nm, "_ready"}, 32'(start_ready), 32'd1);
    chk_results(nm, ecnt, efound, epos);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_ready", 32'(start_ready), 32'd1);
    chk("rst_busy",  32'(busy),        32'd0);
    chk("rst_hit",   32'(hit),         32'd0);
    chk("rst_done",  32'(done),        32'd0);
    chk("rst_abrt",  32'(aborted),     32'd0);
    chk_results("rst", 0, 0, 0);
    tick();
    rst = 1'b0;
    tick();

    run_job("basic",   4'h6, 4'hA, 8'b11011010, 8'b00100100, 2, 1, 2);
    run_job("overlap", 4'hF, 4'h0, 8'hFF,       8'b11111000, 5, 1, 3);
    run_job("nomatch", 4'h9, 4'h0, 8'h00,       8'b00000000, 0, 0, 0);

    // Abort before shift index 3
    code = 4'h6; seed = 4'hA; stream = 8'b11011010; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick(); tick(); tick();
    chk("abt_hit2", 32'(hit), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abt_pulse", 32'(aborted),     32'd1);
    chk("abt_done",  32'(done),        32'd0);
    chk("abt_hit",   32'(hit),         32'd0);
    chk("abt_ready", 32'(start_ready), 32'd1);
    chk("abt_busy",  32'(busy),        32'd0);
    chk_results("abt", 1, 1, 2);
    tick();
    chk("abt_pulse_off", 32'(aborted), 32'd0);
    chk("abt_done_off",  32'(done),    32'd0);
    chk_results("abt_hold", 1, 1, 2);

    // Abort on final edge while start_valid is held throughout
    code = 4'h6; seed = 4'hA; stream = 8'b11011010; start_valid = 1'b1;
    tick();
    code = 4'h9; seed = 4'h0; stream = 8'h00;
    for (int i = 0; i < W - 1; i++) begin
      chk($sformatf("last_busy%0d", i), 32'(busy), 32'd1);
      tick();
    end
    chk("last_busy7", 32'(busy), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("last_abrt",  32'(aborted),     32'd1);
    chk("last_done",  32'(done),        32'd0);
    chk("last_ready", 32'(start_ready), 32'd1);
    chk_results("last", 2, 1, 2);
    tick();
    start_valid = 1'b0;
    chk("req2_busy", 32'(busy), 32'd1);
    chk_results("req2_clr", 0, 0, 0);
    for (int i = 0; i < W; i++) begin
      tick();
      chk($sformatf("req2_hit%0d", i), 32'(hit), 32'd0);
    end
    chk("req2_done", 32'(done), 32'd1);
    tick();
    chk_results("req2", 0, 0, 0);

    // Async reset between edges during SHIFT
    code = 4'h6; seed = 4'hA; stream = 8'b11011010; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick(); tick(); tick();
    chk("ar_pre_hit", 32'(hit), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_hit",   32'(hit),         32'd0);
    chk("ar_done",  32'(done),        32'd0);
    chk("ar_abrt",  32'(aborted),     32'd0);
    chk("ar_busy",  32'(busy),        32'd0);
    chk("ar_ready", 32'(start_ready), 32'd1);
    chk_results("ar", 0, 0, 0);
    #2 rst = 1'b0;
    tick();
    chk("ar_nopulse_d", 32'(done),    32'd0);
    chk("ar_nopulse_a", 32'(aborted), 32'd0);
    run_job("after_rst", 4'h6, 4'hA, 8'b11011010, 8'b00100100, 2, 1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: timeout reached, expected finish");
    $fatal(1);
  end

endmodule
